// File: rtl/aes_sbox_pipe.sv
// Two-stage pipelined AES SubBytes / InvSubBytes unit with valid/ready flow control,
// synchronous flush and a wrapping count of accepted blocks.
module aes_sbox_pipe #(
    parameter int unsigned NUM_WORDS = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_inv,
    input  logic [NUM_WORDS*32-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_inv,
    output logic [NUM_WORDS*32-1:0]   out_data,
    output logic [15:0]               blk_cnt
);

    localparam int unsigned DW = NUM_WORDS * 32;
    localparam int unsigned NB = NUM_WORDS * 4;

    localparam logic [0:255][7:0] SBOX_FWD = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse table is the permutation inverse of the forward table, built at elaboration.
    function automatic logic [0:255][7:0] invert_sbox(input logic [0:255][7:0] t);
        logic [0:255][7:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) begin
            r[t[i]] = 8'(i);
        end
        return r;
    endfunction

    localparam logic [0:255][7:0] SBOX_INV = invert_sbox(SBOX_FWD);

    logic          s1_valid_q, s1_valid_d;
    logic          s1_inv_q,   s1_inv_d;
    logic [DW-1:0] s1_data_q,  s1_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_inv_q,   out_inv_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [15:0]   blk_cnt_q,   blk_cnt_d;

    logic          s2_adv_c;
    logic          s1_adv_c;
    logic          accept_c;
    logic [DW-1:0] sub_c;
    logic [7:0]    lane_c;

    assign s2_adv_c = !out_valid_q || out_ready;
    assign s1_adv_c = !s1_valid_q || s2_adv_c;
    assign in_ready = s1_adv_c && !flush;
    assign accept_c = in_valid && in_ready;

    // One table lookup per byte lane, mode chosen by the block's own s1_inv.
    always_comb begin
        sub_c  = '0;
        lane_c = '0;
        for (int j = 0; j < int'(NB); j++) begin
            lane_c        = s1_data_q[8*j +: 8];
            sub_c[8*j +: 8] = s1_inv_q ? SBOX_INV[lane_c] : SBOX_FWD[lane_c];
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_inv_d    = s1_inv_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_inv_d   = out_inv_q;
        out_data_d  = out_data_q;
        blk_cnt_d   = blk_cnt_q;

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (s1_adv_c) begin
                s1_valid_d = accept_c;
                if (accept_c) begin
                    s1_inv_d  = in_inv;
                    s1_data_d = in_data;
                end
            end
            if (s2_adv_c) begin
                out_valid_d = s1_valid_q;
                out_inv_d   = s1_inv_q;
                out_data_d  = sub_c;
            end
        end

        if (accept_c) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_inv_q   <= 1'b0;
            out_data_q  <= '0;
            blk_cnt_q   <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_inv_q    <= s1_inv_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_inv_q   <= out_inv_d;
            out_data_q  <= out_data_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inv   = out_inv_q;
    assign out_data  = out_data_q;
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: doc/aes_sbox_pipe.md
# aes_sbox_pipe

Parametrised, pipelined AES byte-substitution unit. Applies the forward S-box (SubBytes) or inverse S-box (InvSubBytes) to every byte of an `NUM_WORDS`×32-bit block, selected per transaction. Sits between the round-key/state registers and the ShiftRows/MixColumns stage of the AES datapath. Adds a valid/ready handshake with backpressure, a synchronous flush and an accepted-block counter.

## Interface
- `NUM_WORDS`, default 10: number of 32-bit words per block. Legal range is 1..16.
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous pipeline clear.
- `in_valid`  in  1: input block valid.
- `in_ready`  out  1: unit can accept a block this cycle.
- `in_inv`  in  1: 0 selects the forward S-box; 1 selects the inverse S-box.
- `in_data`  in  NUM_WORDS*32: input block; byte j is `in_data[8j+:8]`.
- `out_valid`  out  1: output block valid.
- `out_ready`  in  1: downstream accepts the output.
- `out_inv`  out  1: mode that travelled with the block.
- `out_data`  out  NUM_WORDS*32: substituted block.
- `blk_cnt`  out  16: count of accepted input blocks; wraps.

## Operation
- Two register stages:
  - S1 holds `s1_valid`, `s1_inv` and `s1_data`, which are the raw captured input.
  - S2 holds `out_valid`, `out_inv` and `out_data`. Each byte of `out_data` is the table lookup of the matching S1 byte.
- Lookups are combinational between S1 and S2. There are 4·NUM_WORDS lanes. Each lane muxes the forward or inverse 256×8 constant table using `s1_inv`.
- Table contents are the FIPS-197 S-box and inverse S-box.
- Lane mapping: output byte j equals table(input byte j). No byte reordering is done.
- Advance conditions:
  - `s2_adv = !out_valid || out_ready`
  - `s1_adv = !s1_valid || s2_adv`
  - `in_ready = s1_adv && !flush`
  - `in_ready` depends combinationally on `out_ready`.
- Input accept happens when `in_valid && in_ready`. S1 loads `in_data` and `in_inv`, and `s1_valid` is set to 1.
- If S1 advances with no accept, `s1_valid` is set to 0.
- When `s2_adv` is high, S2 loads the substituted S1 contents and `out_valid` takes `s1_valid`.
- When a stage is stalled, it holds its data and mode exactly. `out_data` stays stable while `out_valid && !out_ready`.
- Flush:
  - Setting `flush` high clears `s1_valid` and `out_valid` at the next edge. Flush has priority over accept and over advance.
  - Data registers are not cleared.
  - `blk_cnt` is not cleared.
- `blk_cnt` increments by 1 on every input accept. It wraps from 16'hFFFF to 0.
- Mode is per block. Back-to-back blocks may alternate `in_inv` with no bubble.

## Timing
- Reset values, asserted asynchronously while `rst_n` is low:
  - `out_valid`=0, `out_inv`=0, `out_data`=0, `blk_cnt`=0
  - `s1_valid`=0, `s1_inv`=0, `s1_data`=0
- With `flush` low, `in_ready` is 1 during and immediately after reset.
- Latency: a block accepted at edge k has `out_valid`=1 after edge k+1.
- Throughput: one block per cycle while `out_ready`=1.
- When full (both stages valid) and `out_ready`=0: `in_ready`=0.
- When full and `out_ready`=1 in the same cycle as `in_valid`, the unit accepts and emits in that cycle, with no bubble.
- Empty pipeline: `out_valid`=0. `out_data` keeps its last value, which is don't-care.
- Reset mid-operation drops in-flight blocks immediately. No partial block is ever presented.
- If flush and accept occur in the same cycle, no accept happens because `in_ready`=0, and `blk_cnt` does not increment.

## Test plan
- **Forward lookup:** reset, then `in_data` word0 = 32'h00010203, `in_inv`=0, `out_ready`=1.
  - Expect word0 = 32'h637C777B one cycle after accept.
  - Expect all other words = 32'h63636363 when their input is 0.
- **Inverse lookup:** word0 = 32'h637C777B, `in_inv`=1.
  - Expect word0 = 32'h00010203.
  - Expect input byte 8'h00 to give 8'h52.
- **Alternating modes:** drive 100 back-to-back blocks with random data and `in_inv` toggling each block, `out_ready`=1.
  - Expect one output per cycle, in order, matching a reference model.
  - Expect `out_inv` to match the input mode.
  - Expect `blk_cnt`=100.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with `in_valid`=1.
  - Expect exactly 2 accepts, then `in_ready`=0.
  - Expect `out_data` stable throughout.
  - Release `out_ready`: the blocks drain in order with no loss or duplication.
- **Flush:** with both stages valid, pulse `flush` for 1 cycle.
  - Expect `in_ready`=0 during the pulse, and `out_valid`=0 after it.
  - Expect `blk_cnt` unchanged.
  - Expect the next accepted block to emerge normally.
- **Counter wrap and async reset:** preload by streaming 65 537 blocks.
  - Expect `blk_cnt`=1.
  - Assert `rst_n`=0 mid-stream, between clock edges: expect `out_valid` and `blk_cnt` to go to 0 immediately.
